// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARM pipeline stages.
package cpu_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned PC_STEP    = 4;

    localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FS_BOOT  = 1'b0,
        FS_FETCH = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register payload.
    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instruction;
        logic                  valid;
    } if_id_t;

    // Force a byte address onto a word boundary.
    function automatic logic [WORD_WIDTH-1:0] align_word(input logic [WORD_WIDTH-1:0] addr);
        return {addr[WORD_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with load / hold / flush and a valid bit.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] FLUSH_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t bubble;

    // Bubble payload used on reset and flush.
    always_comb begin
        bubble             = '0;
        bubble.pc          = '0;
        bubble.instruction = FLUSH_INSTR;
        bubble.valid       = 1'b0;
    end

    // Flush outranks load; neither means hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= bubble;
        end else if (flush) begin
            q <= bubble;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, boot/fetch FSM, IF/ID capture, fetch counter.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    input  logic [WORD_WIDTH-1:0] imem_instruction,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic [WORD_WIDTH-1:0] if_id_pc,
    output logic [WORD_WIDTH-1:0] if_id_instruction,
    output logic                  if_id_valid,
    output logic [WORD_WIDTH-1:0] fetch_count
);

    fetch_state_e          state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d, pc_plus4;
    logic [WORD_WIDTH-1:0] count_q;
    logic                  ifid_load, ifid_flush, count_inc;
    if_id_t                ifid_d, ifid_q;

    // State, PC register; pc_out is taken straight from the flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and IF/ID controls; redirect outranks freeze.
    always_comb begin
        state_d                = state_q;
        pc_d                   = pc_q;
        ifid_load              = 1'b0;
        ifid_flush             = 1'b0;
        count_inc              = 1'b0;
        pc_plus4               = pc_q + WORD_WIDTH'(PC_STEP);
        ifid_d                 = '0;
        ifid_d.pc              = pc_plus4;
        ifid_d.instruction     = imem_instruction;
        ifid_d.valid           = 1'b1;
        case (state_q)
            FS_BOOT: begin
                state_d    = FS_FETCH;
                ifid_flush = 1'b1;
            end
            FS_FETCH: begin
                if (branch_taken) begin
                    pc_d       = align_word(branch_addr);
                    ifid_flush = 1'b1;
                end else if (!freeze) begin
                    pc_d      = pc_plus4;
                    ifid_load = 1'b1;
                    count_inc = 1'b1;
                end
            end
            default: begin
                state_d = FS_BOOT;
            end
        endcase
    end

    // Retired-fetch counter: counts only valid captures into IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (count_inc) begin
            count_q <= count_q + WORD_WIDTH'(1);
        end
    end

    if_id_reg #(
        .FLUSH_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign pc_out            = pc_q;
    assign if_id_pc          = ifid_q.pc;
    assign if_id_instruction = ifid_q.instruction;
    assign if_id_valid       = ifid_q.valid;
    assign fetch_count       = count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM pipeline. Owns the program counter and drives the PC into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Applies hazard-unit freeze and EX-stage branch redirects, which flush the wrong-path fetch.
- Keeps a retired-fetch counter for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on flush or bubble.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- freeze  input  1  hazard-unit stall; holds PC and IF/ID.
- branch_taken  input  1  EX-stage redirect request.
- branch_addr  input  32  redirect target byte address.
- imem_instruction  input  32  instruction word returned by instruction memory for pc_out.
- pc_out  output  32  current PC; drives the instruction memory address.
- if_id_pc  output  32  registered PC+4 of the captured instruction.
- if_id_instruction  output  32  registered instruction word.
- if_id_valid  output  1  IF/ID holds a real instruction, not a bubble.
- fetch_count  output  32  number of instructions captured into IF/ID with valid=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc_out=RESET_PC, if_id_pc=0, if_id_instruction=NOP_INSTR, if_id_valid=0, fetch_count=0.
  - FSM enters BOOT.
- FSM has two states:
  - BOOT: first edge after reset release. PC held at RESET_PC. IF/ID loads a bubble. Next state is FETCH unconditionally; freeze and branch_taken are ignored in BOOT.
  - FETCH: normal operation; stays in FETCH until reset.
- PC update in FETCH, in priority order:
  - branch_taken: pc <= {branch_addr[31:2],2'b00}. Misaligned low bits are silently cleared.
  - else freeze: pc holds.
  - else: pc <= pc+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update in FETCH:
  - branch_taken (flush): if_id_valid<=0, if_id_instruction<=NOP_INSTR, if_id_pc<=0.
  - else freeze: all IF/ID fields hold.
  - else: if_id_pc<=pc+4, if_id_instruction<=imem_instruction, if_id_valid<=1.
- branch_taken together with freeze: branch wins for both PC and IF/ID. Redirect is never lost.
- Latency: the instruction at PC appears at if_id_* one edge after pc_out=PC, provided there is no freeze or flush.
- fetch_count increments by 1 on each edge that loads if_id_valid<=1. It wraps at 2^32. It does not count bubbles or held cycles.
- Reset asserted mid-operation: all state is forced immediately to reset values, regardless of clk. An in-flight branch is discarded.
- No combinational path from any input to pc_out; pc_out comes directly from the register.

Decomposition:
- Shared package (cpu_pkg):
  - WORD_WIDTH=32
  - PC_STEP=4
  - NOP_INSTR
  - fetch FSM state enum {FS_BOOT, FS_FETCH}
- One sub-module: if_id_reg. It holds the pipeline register with load/hold/flush controls and valid bit, and is reused as the template for later pipeline registers.
- PC register, FSM and counter stay in fetch_stage.

Test Plan:
- Reset then straight-line fetch:
  - Stimulus: release rst_n, memory model returns E3A00014 at 0, E3A01A01 at 4, E3A02103 at 8.
  - Required: pc_out=0 held through BOOT; if_id_valid=0 after BOOT edge.
  - Required: after the next 3 edges, pc_out=12, if_id_instruction=E3A02103, if_id_pc=12, fetch_count=3.
- Freeze:
  - Stimulus: freeze=1 for 2 cycles with pc_out=8.
  - Required: pc_out stays 8 and IF/ID holds E3A01A01/8/valid.
  - Required: fetch_count unchanged; on release, next edge gives pc_out=12.
- Branch flush:
  - Stimulus: branch_taken=1, branch_addr=0x70 while pc_out=0x94.
  - Required: next edge gives pc_out=0x70, if_id_valid=0, if_id_instruction=NOP_INSTR.
  - Required: the following edge captures the word at 0x70 with if_id_pc=0x74.
- Branch with freeze, misaligned target:
  - Stimulus: branch_taken=1, freeze=1, branch_addr=0x73.
  - Required: pc_out=0x70 and IF/ID flushed.
- Wrap:
  - Stimulus: branch to 0xFFFFFFFC, then no stall.
  - Required: next edge gives pc_out=0, if_id_pc=0.
- Asynchronous reset mid-run:
  - Stimulus: rst_n low between edges while pc_out=0x40 and fetch_count=16.
  - Required: pc_out=0, if_id_valid=0, fetch_count=0 immediately, before the next clk edge.
  - Required: BOOT repeats on release.
